fp_mul_pipe: RTL

FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

---
 rtl/fp_mul_pipe.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/fp_mul_pipe.sv
// ============================================================================
// Module   : fp_mul_pipe
// Brief    : 3-stage signed fixed-point multiplier with trunc/round and
//            wrap/saturate output quantisation, valid/ready flow control.
//            Optional macro FP_MUL_PIPE_SATCNT_EN adds a 16-bit saturation counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_mul_pipe #(
    parameter int NB_IN_A  = 8,
    parameter int NBF_IN_A = 6,
    parameter int NB_IN_B  = 12,
    parameter int NBF_IN_B = 11,
    parameter int NB_OUT   = 12,
    parameter int NBF_OUT  = 11
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic signed [NB_IN_A-1:0] i_A,
    input  logic signed [NB_IN_B-1:0] i_B,
    input  logic [1:0]                i_mode,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic signed [NB_OUT-1:0]  o_data,
    output logic                      o_ovf,
    output logic                      o_ovf_sticky,
    input  logic                      i_clr_ovf
`ifdef FP_MUL_PIPE_SATCNT_EN
    ,
    output logic [15:0]               o_sat_count
`endif
);

    localparam int c_NB_PROD  = NB_IN_A + NB_IN_B;
    localparam int c_NBF_PROD = NBF_IN_A + NBF_IN_B;
    localparam int c_SHIFT    = c_NBF_PROD - NBF_OUT;

    logic w_en;

    // Stage 1: operands and mode
    logic                      r_s1_valid;
    logic signed [NB_IN_A-1:0] r_a;
    logic signed [NB_IN_B-1:0] r_b;
    logic [1:0]                r_s1_mode;

    // Stage 2: full-resolution product
    logic                        r_s2_valid;
    logic signed [c_NB_PROD-1:0] r_prod;
    logic [1:0]                  r_s2_mode;

    logic signed [c_NB_PROD-1:0] w_a_ext;
    logic signed [c_NB_PROD-1:0] w_b_ext;
    logic signed [c_NB_PROD-1:0] w_prod;

    logic signed [c_NB_PROD:0]   w_ext;
    logic signed [c_NB_PROD:0]   w_half;
    logic signed [c_NB_PROD:0]   w_rnd;
    logic signed [c_NB_PROD:0]   w_q;
    logic                        w_ovf;
    logic                        w_sat_mode;
    logic [NB_OUT-1:0]           w_data;
    logic                        w_emit_ovf;

`ifdef FP_MUL_PIPE_SATCNT_EN
    logic        r_out_sat;
    logic [15:0] r_sat_count;
`endif

    assign w_en    = i_ready | ~o_valid;
    assign o_ready = w_en;

    // Full-width sign extension keeps the product exact in c_NB_PROD bits
    assign w_a_ext = {{NB_IN_B{r_a[NB_IN_A-1]}}, r_a};
    assign w_b_ext = {{NB_IN_A{r_b[NB_IN_B-1]}}, r_b};
    assign w_prod  = w_a_ext * w_b_ext;

    // One guard bit above the product so adding the half LSB cannot wrap
    assign w_ext = {r_prod[c_NB_PROD-1], r_prod};

    generate
        if (c_SHIFT > 0) begin : g_round
            localparam logic [c_NB_PROD:0] c_HALF =
                {{c_NB_PROD{1'b0}}, 1'b1} << (c_SHIFT - 1);
            assign w_half = r_s2_mode[1] ? $signed(c_HALF) : '0;
        end else begin : g_no_round
            assign w_half = '0;
        end
    endgenerate

    assign w_rnd = w_ext + w_half;
    assign w_q   = w_rnd >>> c_SHIFT;

    // In range only if every bit from the output sign upward agrees
    assign w_ovf      = ~((&w_q[c_NB_PROD:NB_OUT-1]) | ~(|w_q[c_NB_PROD:NB_OUT-1]));
    assign w_sat_mode = r_s2_mode[0] ^ r_s2_mode[1];

    always_comb begin
        w_data = w_q[NB_OUT-1:0];
        if (w_ovf && w_sat_mode) begin
            w_data = {w_q[c_NB_PROD], {(NB_OUT-1){~w_q[c_NB_PROD]}}};
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_s1_valid <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_s1_mode  <= '0;
            r_s2_valid <= 1'b0;
            r_prod     <= '0;
            r_s2_mode  <= '0;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_ovf      <= 1'b0;
        end else if (w_en) begin
            r_s1_valid <= i_valid;
            r_a        <= i_A;
            r_b        <= i_B;
            r_s1_mode  <= i_mode;
            r_s2_valid <= r_s1_valid;
            r_prod     <= w_prod;
            r_s2_mode  <= r_s1_mode;
            o_valid    <= r_s2_valid;
            o_data     <= w_data;
            o_ovf      <= w_ovf;
        end
    end

    assign w_emit_ovf = o_valid & i_ready & o_ovf;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_ovf_sticky <= 1'b0;
        end else if (w_emit_ovf) begin
            o_ovf_sticky <= 1'b1;
        end else if (i_clr_ovf) begin
            o_ovf_sticky <= 1'b0;
        end
    end

`ifdef FP_MUL_PIPE_SATCNT_EN
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_out_sat   <= 1'b0;
            r_sat_count <= '0;
        end else begin
            if (w_en) begin
                r_out_sat <= w_sat_mode;
            end
            if (w_emit_ovf && r_out_sat) begin
                if (i_clr_ovf) begin
                    r_sat_count <= 16'd1;
                end else if (r_sat_count != 16'hFFFF) begin
                    r_sat_count <= r_sat_count + 16'd1;
                end
            end else if (i_clr_ovf) begin
                r_sat_count <= '0;
            end
        end
    end

    assign o_sat_count = r_sat_count;
`endif

endmodule

`default_nettype wire
